// File: rtl/led_wave_pkg.sv
// rtl/led_wave_pkg.sv - shared mode encodings and helper functions for the LED animator
package led_wave_pkg;

    localparam logic [1:0] MODE_WAVE    = 2'd0;
    localparam logic [1:0] MODE_BREATHE = 2'd1;
    localparam logic [1:0] MODE_CHASE   = 2'd2;
    localparam logic [1:0] MODE_STATIC  = 2'd3;

    // Ceiling log2 for elaboration-time sizing.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int k = 0; k < 31; k++) begin
            if ((1 << k) < v) begin
                r = k + 1;
            end
        end
        return r;
    endfunction

    // Fold a (pwm_bits+1)-bit ramp into a triangle: rising half passes, falling half inverts.
    function automatic logic [31:0] tri_fold(input logic [31:0] t, input int pwm_bits);
        logic [31:0] mask;
        mask = (32'd1 << pwm_bits) - 32'd1;
        if (((t >> pwm_bits) & 32'd1) != 32'd0) begin
            return ~t & mask;
        end
        return t & mask;
    endfunction

    // Square-law brightness correction; full scale is pinned so max stays max.
    function automatic logic [31:0] gamma(input logic [31:0] b, input int pwm_bits);
        logic [31:0] mask;
        mask = (32'd1 << pwm_bits) - 32'd1;
        if (b == mask) begin
            return mask;
        end
        return (b * b) >> pwm_bits;
    endfunction

endpackage

// File: rtl/led_pwm_chan.sv
// rtl/led_pwm_chan.sv - one PWM channel: brightness latch, optional gamma, compare, led register
//  Ports: i_clk, i_rst (sync, active high), i_pwm_cnt (shared counter),
//         i_eop (end of PWM period), i_b (raw brightness), o_led (registered drive).
//  Macro LED_PWM_WAVE_GAMMA_EN selects square-law correction of the latched value.
module led_pwm_chan
    import led_wave_pkg::*;
#(
    parameter int PWM_BITS = 8
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [PWM_BITS-1:0] i_pwm_cnt,
    input  logic                i_eop,
    input  logic [PWM_BITS-1:0] i_b,
    output logic                o_led
);

    logic [PWM_BITS-1:0] r_br;
    logic [PWM_BITS-1:0] w_lat;

`ifdef LED_PWM_WAVE_GAMMA_EN
    assign w_lat = PWM_BITS'(gamma(32'(i_b), PWM_BITS));
`else
    assign w_lat = i_b;
`endif

    // Brightness only moves on the period boundary so a duty cycle is never split.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_br  <= '0;
            o_led <= 1'b0;
        end else begin
            if (i_eop) begin
                r_br <= w_lat;
            end
            o_led <= (i_pwm_cnt < r_br);
        end
    end

endmodule

// File: rtl/led_pwm_wave.sv
// rtl/led_pwm_wave.sv - multi-channel LED animator: prescaler, phase accumulator, mode mux, PWM
//  Ports: clk, rst (sync, active high), cfg_valid/cfg_ready handshake carrying
//         cfg_mode/cfg_speed/cfg_level, pause (freezes phase only), led (registered PWM).
//  Macro LED_PWM_WAVE_GAMMA_EN enables gamma correction inside each channel.
module led_pwm_wave
    import led_wave_pkg::*;
#(
    parameter int NUM_LEDS   = 8,
    parameter int PWM_BITS   = 8,
    parameter int PHASE_BITS = 16,
    parameter int STEP_DIV   = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [1:0]            cfg_mode,
    input  logic [PHASE_BITS-1:0] cfg_speed,
    input  logic [PWM_BITS-1:0]   cfg_level,
    input  logic                  pause,
    output logic [NUM_LEDS-1:0]   led
);

    localparam int LOG_N   = clog2(NUM_LEDS);
    localparam int PRESC_W = (STEP_DIV > 1) ? clog2(STEP_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(STEP_DIV - 1);

    logic [PRESC_W-1:0]    r_presc;
    logic [PHASE_BITS-1:0] r_phase;
    logic [PWM_BITS-1:0]   r_pwm_cnt;
    logic [1:0]            r_mode;
    logic [PHASE_BITS-1:0] r_speed;
    logic [PWM_BITS-1:0]   r_level;

    logic w_step;
    logic w_eop;
    logic w_xfer;
    logic [NUM_LEDS-1:0] w_led;

    assign w_step    = (r_presc == PRESC_LAST);
    assign w_eop     = &r_pwm_cnt;
    // Gated by rst so no transfer is offered while the counter is being cleared.
    assign cfg_ready = w_eop & ~rst;
    assign w_xfer    = cfg_valid & cfg_ready;
    assign led       = w_led;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc   <= '0;
            r_phase   <= '0;
            r_pwm_cnt <= '0;
            r_mode    <= MODE_WAVE;
            r_speed   <= PHASE_BITS'(1);
            r_level   <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
            r_presc   <= w_step ? '0 : r_presc + 1'b1;
            // Uses the speed held before any same-cycle config transfer.
            if (w_step && !pause) begin
                r_phase <= r_phase + r_speed;
            end
            if (w_xfer) begin
                r_mode  <= cfg_mode;
                r_speed <= cfg_speed;
                r_level <= cfg_level;
            end
        end
    end

    for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_ch
        // Channel spacing of one NUM_LEDS-th of the phase circle.
        localparam logic [PHASE_BITS-1:0] OFS = PHASE_BITS'(gi) << (PHASE_BITS - LOG_N);

        logic [PHASE_BITS-1:0] w_p;
        logic [PWM_BITS-1:0]   w_tri;
        logic [PWM_BITS-1:0]   w_b;

        always_comb begin
            w_p   = r_phase + ((r_mode == MODE_WAVE) ? OFS : '0);
            w_tri = PWM_BITS'(tri_fold(32'(w_p >> (PHASE_BITS - PWM_BITS - 1)), PWM_BITS));
            w_b   = '0;
            case (r_mode)
                MODE_WAVE, MODE_BREATHE: w_b = w_tri;
                MODE_CHASE:  w_b = (r_phase[PHASE_BITS-1 -: LOG_N] == LOG_N'(gi)) ? '1 : '0;
                default:     w_b = r_level;
            endcase
        end

        led_pwm_chan #(
            .PWM_BITS(PWM_BITS)
        ) u_chan (
            .i_clk     (clk),
            .i_rst     (rst),
            .i_pwm_cnt (r_pwm_cnt),
            .i_eop     (w_eop),
            .i_b       (w_b),
            .o_led     (w_led[gi])
        );
    end

endmodule

// File: tb/tb_led_pwm_wave.sv
// tb/tb_led_pwm_wave.sv - directed self-checking bench for led_pwm_wave
module tb_led_pwm_wave;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [1:0] cfg_mode;
    logic [7:0] cfg_speed;
    logic [3:0] cfg_level;
    logic       pause;
    logic [3:0] led;

    int total = 0;
    int bad   = 0;
    int cnt[4];
    int n;
    logic [3:0] led_seen;
    logic       rdy_seen;

    always #5 clk = ~clk;

    led_pwm_wave #(
        .NUM_LEDS(4), .PWM_BITS(4), .PHASE_BITS(8), .STEP_DIV(2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_mode  (cfg_mode),
        .cfg_speed (cfg_speed),
        .cfg_level (cfg_level),
        .pause     (pause),
        .led       (led)
    );

    // Expected latched duty for a raw brightness (square law when gamma is built in).
    function automatic int gm(input int b);
`ifdef LED_PWM_WAVE_GAMMA_EN
        if (b == 15) return 15;
        return (b * b) >> 4;
`else
        return b;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int got, input int exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic wait_ready();
        int k;
        k = 0;
        while (!cfg_ready && k < 40) begin
            tick();
            k++;
        end
        if (!cfg_ready) check("ready_timeout", 0, 1);
    endtask

    // Count high cycles per led over the 16 led-cycles of one period.
    task automatic count16();
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        for (int c = 0; c < 16; c++) begin
            tick();
            for (int i = 0; i < 4; i++) cnt[i] += int'(led[i]);
        end
    endtask

    // Duty of the period whose brightness is latched at the next boundary.
    task automatic measure();
        wait_ready();
        tick();
        count16();
    endtask

    task automatic expect4(input string tag, input int e0, input int e1, input int e2, input int e3);
        check({tag, "_l0"}, cnt[0], e0);
        check({tag, "_l1"}, cnt[1], e1);
        check({tag, "_l2"}, cnt[2], e2);
        check({tag, "_l3"}, cnt[3], e3);
    endtask

    // Config transfer; cnt afterwards holds the period right after it (old duty).
    task automatic xfer(input logic [1:0] m, input logic [7:0] s, input logic [3:0] l);
        cfg_mode  = m;
        cfg_speed = s;
        cfg_level = l;
        cfg_valid = 1'b1;
        wait_ready();
        tick();
        cfg_valid = 1'b0;
        count16();
    endtask

    task automatic run_steps(input int steps);
        pause = 1'b0;
        for (int c = 0; c < 2 * steps; c++) tick();
        pause = 1'b1;
    endtask

    initial begin
        rst = 1'b1; cfg_valid = 1'b0; cfg_mode = 2'd0; cfg_speed = 8'd0;
        cfg_level = 4'd0; pause = 1'b0;
        for (int c = 0; c < 3; c++) tick();
        rst = 1'b0;
        for (int c = 0; c < 20; c++) tick();

        // Reset mid-period
        rst = 1'b1;
        led_seen = '0; rdy_seen = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            led_seen |= led;
            rdy_seen |= cfg_ready;
        end
        check("rst_led", int'(led_seen), 0);
        check("rst_ready", int'(rdy_seen), 0);
        rst = 1'b0;
        n = 0; led_seen = '0;
        while (!cfg_ready && n < 40) begin
            tick();
            n++;
            led_seen |= led;
        end
        check("first_ready_clk", n, 15);
        check("post_rst_led", int'(led_seen), 0);

        // STATIC level 0
        xfer(2'd3, 8'd1, 4'd0);
        measure();
        expect4("static0_a", 0, 0, 0, 0);
        measure();
        expect4("static0_b", 0, 0, 0, 0);

        // Handshake: valid raised at pwm_cnt=3, new level 15
        wait_ready();
        tick();
        for (int c = 0; c < 3; c++) tick();
        check("hs_ready_low", int'(cfg_ready), 0);
        cfg_mode = 2'd3; cfg_speed = 8'd1; cfg_level = 4'd15; cfg_valid = 1'b1;
        n = 0;
        while (!cfg_ready && n < 40) begin
            tick();
            n++;
        end
        check("hs_wait", n, 12);
        tick();
        cfg_valid = 1'b0;
        check("hs_ready_1clk", int'(cfg_ready), 0);
        count16();
        expect4("hs_old", 0, 0, 0, 0);
        measure();
        expect4("static15", gm(15), gm(15), gm(15), gm(15));

        // STATIC level 8 (gamma: 4)
        xfer(2'd3, 8'd1, 4'd8);
        measure();
        expect4("static8", gm(8), gm(8), gm(8), gm(8));

        // WAVE from reset config (speed 1) with phase held by pause
        pause = 1'b1;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        measure();
        expect4("wave_p0", gm(0), gm(8), gm(15), gm(7));
        run_steps(8);
        measure();
        expect4("wave_p8", gm(1), gm(9), gm(14), gm(6));
        run_steps(112);
        measure();
        expect4("wave_p120", gm(15), gm(8), gm(0), gm(7));
        run_steps(136);
        measure();
        expect4("wave_wrap0", gm(0), gm(8), gm(15), gm(7));
        run_steps(256);
        measure();
        expect4("wave_512", gm(0), gm(8), gm(15), gm(7));

        // CHASE speed 64, phase currently 0
        xfer(2'd2, 8'd64, 4'd0);
        measure();
        expect4("chase0", 15, 0, 0, 0);
        run_steps(1);
        measure();
        expect4("chase1", 0, 15, 0, 0);
        run_steps(1);
        measure();
        expect4("chase2", 0, 0, 15, 0);
        run_steps(1);
        measure();
        expect4("chase3", 0, 0, 0, 15);
        run_steps(1);
        measure();
        expect4("chase4", 15, 0, 0, 0);
        measure();
        measure();
        expect4("chase_paused", 15, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
